seg7_frame_reader: RTL and testbench

Reads a multiplexed, active-low seven-segment display bus (segment lines plus one-hot active-low anode enables) and reconstructs the hex value shown on each digit. This is the inverse of the team's hex-to-seven-segment decoder. It lets self-checking logic and on-board monitors recover the displayed number from the pins driving the display. Output is one frame per complete scan of all digits.

---
 rtl/seg7_frame_reader.sv | 237 +++++++++++++++++++++++
 tb/tb_seg7_frame_reader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_frame_reader.sv
// Recovers the hex value on each digit of a multiplexed active-low seven-segment bus.
// Define SEG7_READER_TIMEOUT_EN to enable the idle-bus timeout and the stalled flag.
module seg7_frame_reader #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [0:6]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   blank_out,
  output logic [NUM_DIGITS-1:0]   err_out,
  output logic                    frame_valid,
  output logic                    stalled
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_DWELL  = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // Returns {err, blank, value[3:0]} for one segment pattern (a..g, active-low).
  function automatic logic [5:0] decode_seg(input logic [0:6] s);
    case (s)
      7'b0000001: decode_seg = {2'b00, 4'h0};
      7'b1001111: decode_seg = {2'b00, 4'h1};
      7'b0010010: decode_seg = {2'b00, 4'h2};
      7'b0000110: decode_seg = {2'b00, 4'h3};
      7'b1001100: decode_seg = {2'b00, 4'h4};
      7'b0100100: decode_seg = {2'b00, 4'h5};
      7'b0100000: decode_seg = {2'b00, 4'h6};
      7'b0001111: decode_seg = {2'b00, 4'h7};
      7'b0000000: decode_seg = {2'b00, 4'h8};
      7'b0000100: decode_seg = {2'b00, 4'h9};
      7'b0001000: decode_seg = {2'b00, 4'hA};
      7'b1100000: decode_seg = {2'b00, 4'hB};
      7'b0110001: decode_seg = {2'b00, 4'hC};
      7'b1000010: decode_seg = {2'b00, 4'hD};
      7'b0110000: decode_seg = {2'b00, 4'hE};
      7'b0111000: decode_seg = {2'b00, 4'hF};
      7'b1111111: decode_seg = {2'b01, 4'h0};
      default:    decode_seg = {2'b10, 4'h0};
    endcase
  endfunction

  logic [NUM_DIGITS-1:0]   smp_an_q, smp_an_d, prv_an_q, prv_an_d;
  logic [0:6]              smp_seg_q, smp_seg_d, prv_seg_q, prv_seg_d;
  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0]   shadow_blank_q, shadow_blank_d;
  logic [NUM_DIGITS-1:0]   shadow_err_q, shadow_err_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic                    frame_valid_q, frame_valid_d;

  logic                    smp_valid;
  logic                    smp_same;
  logic                    capture;
  logic [NUM_DIGITS-1:0]   cap_mask;
  logic [5:0]              dec;
  logic                    tmo_hit;

  assign smp_valid = ($countones(~smp_an_q) == 32'd1);
  assign smp_same  = (smp_an_q == prv_an_q) && (smp_seg_q == prv_seg_q);
  assign dec       = decode_seg(smp_seg_q);
  assign cap_mask  = capture ? ~smp_an_q : {NUM_DIGITS{1'b0}};

  // Sample pipeline plus dwell/stability FSM deciding when a digit is captured
  always_comb begin
    smp_an_d  = an_in;
    smp_seg_d = seg_in;
    prv_an_d  = smp_an_q;
    prv_seg_d = smp_seg_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    case (state_q)
      ST_SEARCH: begin
        if (smp_valid) begin
          state_d = ST_DWELL;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = ST_SEARCH;
          cnt_d   = {CNT_W{1'b0}};
        end
      end
      ST_DWELL, ST_HOLD: begin
        if (!smp_valid) begin
          state_d = ST_SEARCH;
          cnt_d   = {CNT_W{1'b0}};
        end else if (!smp_same) begin
          state_d = ST_DWELL;
          cnt_d   = CNT_ONE;
        end else if (state_q == ST_HOLD) begin
          state_d = ST_HOLD;
          cnt_d   = cnt_q;
        end else if ((cnt_q + CNT_ONE) == CNT_TOP) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_TOP;
          capture = 1'b1;
        end else begin
          state_d = ST_DWELL;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_SEARCH;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Shadow slots, seen tracking and frame emission; a same-edge capture joins the next frame
  always_comb begin
    digits_d      = digits_q;
    blank_d       = blank_q;
    err_d         = err_q;
    frame_valid_d = 1'b0;
    seen_d        = seen_q;
    if (&seen_q) begin
      digits_d      = shadow_val_q;
      blank_d       = shadow_blank_q;
      err_d         = shadow_err_q;
      frame_valid_d = 1'b1;
      seen_d        = cap_mask;
    end else begin
      seen_d        = seen_q | cap_mask;
    end
    if (tmo_hit) begin
      seen_d = {NUM_DIGITS{1'b0}};
    end else begin
      seen_d = seen_d;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      shadow_val_d[4*i +: 4] = cap_mask[i] ? dec[3:0] : shadow_val_q[4*i +: 4];
      shadow_blank_d[i]      = cap_mask[i] ? dec[4]   : shadow_blank_q[i];
      shadow_err_d[i]        = cap_mask[i] ? dec[5]   : shadow_err_q[i];
    end
  end

  // State registers with synchronous reset; reset drops any partial frame
  always_ff @(posedge clk) begin
    if (rst) begin
      smp_an_q       <= {NUM_DIGITS{1'b1}};
      smp_seg_q      <= 7'b1111111;
      prv_an_q       <= {NUM_DIGITS{1'b1}};
      prv_seg_q      <= 7'b1111111;
      state_q        <= ST_SEARCH;
      cnt_q          <= {CNT_W{1'b0}};
      shadow_val_q   <= {(4*NUM_DIGITS){1'b0}};
      shadow_blank_q <= {NUM_DIGITS{1'b0}};
      shadow_err_q   <= {NUM_DIGITS{1'b0}};
      seen_q         <= {NUM_DIGITS{1'b0}};
      digits_q       <= {(4*NUM_DIGITS){1'b0}};
      blank_q        <= {NUM_DIGITS{1'b0}};
      err_q          <= {NUM_DIGITS{1'b0}};
      frame_valid_q  <= 1'b0;
    end else begin
      smp_an_q       <= smp_an_d;
      smp_seg_q      <= smp_seg_d;
      prv_an_q       <= prv_an_d;
      prv_seg_q      <= prv_seg_d;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shadow_val_q   <= shadow_val_d;
      shadow_blank_q <= shadow_blank_d;
      shadow_err_q   <= shadow_err_d;
      seen_q         <= seen_d;
      digits_q       <= digits_d;
      blank_q        <= blank_d;
      err_q          <= err_d;
      frame_valid_q  <= frame_valid_d;
    end
  end

`ifdef SEG7_READER_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1'b1);
  localparam logic [TMO_W-1:0] TMO_TOP = TMO_W'(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             stalled_q, stalled_d;

  // Idle/invalid sample counter; saturates, and the capture after a stall clears the flag
  always_comb begin
    tmo_d   = tmo_q;
    tmo_hit = 1'b0;
    if (smp_valid) begin
      tmo_d = {TMO_W{1'b0}};
    end else if (tmo_q != TMO_TOP) begin
      tmo_d   = tmo_q + TMO_ONE;
      tmo_hit = ((tmo_q + TMO_ONE) == TMO_TOP);
    end else begin
      tmo_d = tmo_q;
    end
    if (capture) begin
      stalled_d = 1'b0;
    end else if (tmo_hit) begin
      stalled_d = 1'b1;
    end else begin
      stalled_d = stalled_q;
    end
  end

  // Timeout registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q     <= {TMO_W{1'b0}};
      stalled_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      stalled_q <= stalled_d;
    end
  end

  assign stalled = stalled_q;
`else
  assign tmo_hit = 1'b0;
  assign stalled = 1'b0;
`endif

  assign digits_out  = digits_q;
  assign blank_out   = blank_q;
  assign err_out     = err_q;
  assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_seg7_frame_reader.sv
// Bench for seg7_frame_reader: run-length reference model checked every cycle,
// directed scenarios with literal expectations, then randomized bus traffic.
module tb_seg7_frame_reader;

  localparam int ND      = 4;
  localparam int STABLE  = 4;
  localparam int TIMEOUT = 100;
  localparam logic [ND-1:0] ONE_HOT = ND'(1'b1);
`ifdef SEG7_READER_TIMEOUT_EN
  localparam logic STALL_EXP = 1'b1;
`else
  localparam logic STALL_EXP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [0:6]      seg_in = 7'b1111111;
  logic [ND-1:0]   an_in = {ND{1'b1}};
  logic [4*ND-1:0] digits_out;
  logic [ND-1:0]   blank_out, err_out;
  logic            frame_valid, stalled;

  seg7_frame_reader #(
    .NUM_DIGITS(ND), .STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in),
    .digits_out(digits_out), .blank_out(blank_out), .err_out(err_out),
    .frame_valid(frame_valid), .stalled(stalled)
  );

  always #5 clk = ~clk;

  logic [0:6] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  int n_checks = 0;
  int n_errors = 0;
  int fv_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // {err, blank, value} from the published segment table
  function automatic logic [5:0] ref_decode(input logic [0:6] p);
    logic [5:0] r;
    r = 6'b100000;
    if (p == 7'b1111111) r = 6'b010000;
    for (int j = 0; j < 16; j++) if (p == seg_tab[j]) r = {2'b00, 4'(j)};
    return r;
  endfunction

  // Reference model state
  logic            m_init = 1'b0;
  logic [ND-1:0]   m_smp_an;
  logic [0:6]      m_smp_seg;
  int              m_run;
  logic [4*ND-1:0] m_sh_val;
  logic [ND-1:0]   m_sh_blank, m_sh_err, m_seen;
  logic [4*ND-1:0] m_digits;
  logic [ND-1:0]   m_blank, m_err;
  logic            m_fv, m_stalled;
  int              m_tmo;

  // A digit is captured when its sample has been seen STABLE times in a row
  always @(posedge clk) begin : ref_model
    logic            valid, cap, stl_n, new_valid;
    logic [ND-1:0]   seen_n, shb_n, she_n;
    logic [4*ND-1:0] shv_n;
    logic [5:0]      d;
    int              idx, tmo_n;
    if (rst) begin
      m_init <= 1'b1; m_smp_an <= {ND{1'b1}}; m_smp_seg <= 7'b1111111; m_run <= 0;
      m_sh_val <= '0; m_sh_blank <= '0; m_sh_err <= '0; m_seen <= '0;
      m_digits <= '0; m_blank <= '0; m_err <= '0; m_fv <= 1'b0; m_stalled <= 1'b0; m_tmo <= 0;
    end else begin
      valid = ($countones(~m_smp_an) == 1);
      cap   = valid && (m_run == STABLE);
      seen_n = m_seen; shv_n = m_sh_val; shb_n = m_sh_blank; she_n = m_sh_err;
      stl_n = m_stalled; tmo_n = m_tmo;
      if (&m_seen) begin
        m_digits <= m_sh_val; m_blank <= m_sh_blank; m_err <= m_sh_err;
        m_fv <= 1'b1; seen_n = '0;
      end else begin
        m_fv <= 1'b0;
      end
      if (cap) begin
        idx = 0;
        for (int j = 0; j < ND; j++) if (!m_smp_an[j]) idx = j;
        d = ref_decode(m_smp_seg);
        shv_n[4*idx +: 4] = d[3:0]; shb_n[idx] = d[4]; she_n[idx] = d[5];
        seen_n[idx] = 1'b1;
      end
`ifdef SEG7_READER_TIMEOUT_EN
      if (!valid) begin
        if (tmo_n < TIMEOUT) begin
          tmo_n++;
          if (tmo_n == TIMEOUT) begin stl_n = 1'b1; seen_n = '0; end
        end
      end else begin
        tmo_n = 0;
      end
      if (cap) stl_n = 1'b0;
`endif
      m_seen <= seen_n; m_sh_val <= shv_n; m_sh_blank <= shb_n; m_sh_err <= she_n;
      m_stalled <= stl_n; m_tmo <= tmo_n;
      new_valid = ($countones(~an_in) == 1);
      if (new_valid && an_in == m_smp_an && seg_in == m_smp_seg) m_run <= m_run + 1;
      else if (new_valid) m_run <= 1;
      else m_run <= 0;
      m_smp_an <= an_in; m_smp_seg <= seg_in;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (m_init) begin
      chk("digits_out", 32'(digits_out), 32'(m_digits));
      chk("blank_out", 32'(blank_out), 32'(m_blank));
      chk("err_out", 32'(err_out), 32'(m_err));
      chk("frame_valid", 32'(frame_valid), 32'(m_fv));
      chk("stalled", 32'(stalled), 32'(m_stalled));
      if (frame_valid) fv_count <= fv_count + 1;
    end
  end

  task automatic show(input int dg, input logic [0:6] pat, input int cyc);
    for (int k = 0; k < cyc; k++) begin
      @(negedge clk); rst = 1'b0; an_in = ~(ONE_HOT << dg); seg_in = pat;
    end
  endtask

  task automatic bus(input logic [ND-1:0] an, input logic [0:6] pat, input int cyc);
    for (int k = 0; k < cyc; k++) begin
      @(negedge clk); rst = 1'b0; an_in = an; seg_in = pat;
    end
  endtask

  task automatic reset_for(input int cyc);
    for (int k = 0; k < cyc; k++) begin
      @(negedge clk); rst = 1'b1; an_in = {ND{1'b1}}; seg_in = 7'b1111111;
    end
  endtask

  task automatic lit(input string name, input logic [31:0] dut_v, input logic [31:0] mdl_v,
                     input logic [31:0] exp);
    chk({name, "_dut"}, dut_v, exp);
    chk({name, "_model"}, mdl_v, exp);
  endtask

  task automatic scan4(input int v0, input int v1, input int v2, input int v3);
    show(0, seg_tab[v0], 8); show(1, seg_tab[v1], 8);
    show(2, seg_tab[v2], 8); show(3, seg_tab[v3], 8);
    bus({ND{1'b1}}, 7'b1111111, 4);
  endtask

  initial begin
    int fv0, r, dg, d2, cyc;
    logic [0:6] pat;

    reset_for(2);
    bus({ND{1'b1}}, 7'b1111111, 1);
    #1;
    lit("rst_digits", 32'(digits_out), 32'(m_digits), 32'h0);
    lit("rst_fv", 32'(frame_valid), 32'(m_fv), 32'h0);
    chk("rst_blank_err", 32'({blank_out, err_out}), 32'h0);

    // Clean scan of 1,2,3,A
    fv0 = fv_count;
    scan4(1, 2, 3, 10);
    #1;
    chk("t1_frames", 32'(fv_count - fv0), 32'd1);
    lit("t1_digits", 32'(digits_out), 32'(m_digits), 32'hA321);
    lit("t1_blank_err", 32'({blank_out, err_out}), 32'({m_blank, m_err}), 32'h0);

    // Digit 1 held too briefly; the next scan completes using the older slots 2 and 3
    reset_for(1);
    fv0 = fv_count;
    show(0, seg_tab[1], 8); show(1, seg_tab[2], 3);
    show(2, seg_tab[3], 8); show(3, seg_tab[10], 8);
    bus({ND{1'b1}}, 7'b1111111, 4);
    #1;
    chk("t2_short_frames", 32'(fv_count - fv0), 32'd0);
    fv0 = fv_count;
    scan4(4, 5, 6, 7);
    #1;
    chk("t2_clean_frames", 32'(fv_count - fv0), 32'd1);
    lit("t2_digits", 32'(digits_out), 32'(m_digits), 32'hA354);

    // Blank and unrecognised patterns
    reset_for(1);
    fv0 = fv_count;
    show(0, seg_tab[5], 8); show(1, seg_tab[7], 8);
    show(2, 7'b1111111, 8); show(3, 7'b1010101, 8);
    bus({ND{1'b1}}, 7'b1111111, 4);
    #1;
    chk("t3_frames", 32'(fv_count - fv0), 32'd1);
    lit("t3_digits", 32'(digits_out), 32'(m_digits), 32'h0075);
    lit("t3_blank", 32'(blank_out), 32'(m_blank), 32'b0100);
    lit("t3_err", 32'(err_out), 32'(m_err), 32'b1000);

    // Two anodes low mid-scan captures nothing
    reset_for(1);
    fv0 = fv_count;
    show(0, seg_tab[4], 8); show(1, seg_tab[5], 8);
    bus(4'b1100, seg_tab[8], 20);
    #1;
    chk("t4_invalid_frames", 32'(fv_count - fv0), 32'd0);
    show(2, seg_tab[6], 8); show(3, seg_tab[7], 8);
    bus({ND{1'b1}}, 7'b1111111, 4);
    #1;
    chk("t4_frames", 32'(fv_count - fv0), 32'd1);
    lit("t4_digits", 32'(digits_out), 32'(m_digits), 32'h7654);

    // Reset mid-frame discards digits 0 and 1
    reset_for(1);
    fv0 = fv_count;
    show(0, seg_tab[1], 8); show(1, seg_tab[2], 8);
    reset_for(1);
    show(2, seg_tab[3], 8); show(3, seg_tab[4], 8);
    bus({ND{1'b1}}, 7'b1111111, 6);
    #1;
    chk("t5_frames", 32'(fv_count - fv0), 32'd0);
    lit("t5_digits", 32'(digits_out), 32'(m_digits), 32'h0);
    chk("t5_blank_err", 32'({blank_out, err_out}), 32'h0);

    // Long idle bus: stalls when the timeout is built in, then a full scan recovers
    reset_for(1);
    show(0, seg_tab[1], 8); show(1, seg_tab[2], 8);
    bus({ND{1'b1}}, 7'b1111111, TIMEOUT + 5);
    #1;
    lit("t6_stalled", 32'(stalled), 32'(m_stalled), 32'(STALL_EXP));
    fv0 = fv_count;
    show(0, seg_tab[8], 8);
    #1;
    lit("t6_stall_clear", 32'(stalled), 32'(m_stalled), 32'h0);
    show(1, seg_tab[9], 8); show(2, seg_tab[10], 8); show(3, seg_tab[11], 8);
    bus({ND{1'b1}}, 7'b1111111, 4);
    #1;
    chk("t6_frames", 32'(fv_count - fv0), 32'd1);
    lit("t6_digits", 32'(digits_out), 32'(m_digits), 32'hBA98);

    // Randomized traffic checked every cycle by the model
    for (int it = 0; it < 400; it++) begin
      r = int'($urandom_range(0, 39));
      if (r == 0) begin
        reset_for(1);
      end else if (r == 1) begin
        bus({ND{1'b1}}, 7'b1111111, int'($urandom_range(90, 120)));
      end else if (r < 5) begin
        bus({ND{1'b1}}, 7'($urandom), int'($urandom_range(1, 8)));
      end else if (r < 8) begin
        dg = int'($urandom_range(0, ND - 1));
        d2 = (dg + 1 + int'($urandom_range(0, ND - 2))) % ND;
        bus(~((ONE_HOT << dg) | (ONE_HOT << d2)), 7'($urandom), int'($urandom_range(1, 6)));
      end else begin
        dg = int'($urandom_range(0, ND - 1));
        r = int'($urandom_range(0, 9));
        if (r == 0) pat = 7'($urandom);
        else if (r == 1) pat = 7'b1111111;
        else pat = seg_tab[$urandom_range(0, 15)];
        cyc = int'($urandom_range(1, 10));
        show(dg, pat, cyc);
      end
    end
    bus({ND{1'b1}}, 7'b1111111, 4);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
